// File: rtl/bcd_seg_display.sv
// Score/combo readout: sequential double-dabble binary-to-BCD conversion driving active-low 7-segment digits.
// Optional macro BCD_SEG_SAT_EN: on overflow show all nines instead of the low decimal digits.
module bcd_seg_display #(
  parameter int BIN_W    = 16,
  parameter int N_DIGITS = 4,
  parameter int LZ_BLANK = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic [BIN_W-1:0]      i_Value,
  input  logic                  i_Valid,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic [7*N_DIGITS-1:0] o_Seg,
  output logic                  o_Ovf
);

  // state  | meaning
  // IDLE   | waiting for i_Valid, display holds last result
  // SHIFT  | one add-3/shift step per cycle, BIN_W steps
  // UPDATE | publish digits and overflow, relaunch if a request is pending

  // (BIN_W+2)/3 digits always cover 2^BIN_W-1; extra guard digits are harmless.
  localparam int BCD_DIG_MIN = (BIN_W + 2) / 3;
  localparam int TOT_DIG     = (N_DIGITS > BCD_DIG_MIN) ? N_DIGITS : BCD_DIG_MIN;
  localparam int BCD_W       = 4 * TOT_DIG;
  localparam int CNT_W       = $clog2(BIN_W + 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;
  localparam logic [6:0] SEG_NINE  = 7'h10;

  function automatic logic [7*N_DIGITS-1:0] reset_seg();
    logic [7*N_DIGITS-1:0] r;
    r = '0;
    for (int d = 0; d < N_DIGITS; d++) begin
      r[7*d +: 7] = ((LZ_BLANK != 0) && (d != 0)) ? SEG_BLANK : SEG_ZERO;
    end
    return r;
  endfunction

  localparam logic [7*N_DIGITS-1:0] RST_SEG = reset_seg();

  function automatic logic [6:0] seg_of(input logic [3:0] dig);
    case (dig)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [BIN_W-1:0]      bin_sr;
  logic [BCD_W-1:0]      bcd_sr;
  logic [BCD_W-1:0]      bcd_adj;
  logic [CNT_W-1:0]      cnt;
  logic                  pend_flag;
  logic [BIN_W-1:0]      pend_val;

  logic                  load;
  logic [BIN_W-1:0]      load_val;
  logic                  do_shift;
  logic                  do_update;

  logic                  ovf_c;
  logic [7*N_DIGITS-1:0] seg_c;
  logic [3:0]            nib;
  logic                  nz_above;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // An i_Valid seen in UPDATE is treated as pending and wins over an older pending value.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_val  = i_Value;
    do_shift  = 1'b0;
    do_update = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_Valid) begin
          load      = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        do_shift = 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_nxt = S_UPDATE;
        end
      end
      S_UPDATE: begin
        do_update = 1'b1;
        if (i_Valid || pend_flag) begin
          load      = 1'b1;
          load_val  = i_Valid ? i_Value : pend_val;
          state_nxt = S_SHIFT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_Busy = (state != S_IDLE);

  always_comb begin
    bcd_adj = bcd_sr;
    for (int d = 0; d < TOT_DIG; d++) begin
      if (bcd_sr[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      bin_sr <= '0;
      bcd_sr <= '0;
      cnt    <= '0;
    end else if (load) begin
      bin_sr <= load_val;
      bcd_sr <= '0;
      cnt    <= CNT_W'(BIN_W);
    end else if (do_shift) begin
      bcd_sr <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
      bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
      cnt    <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      pend_flag <= 1'b0;
      pend_val  <= '0;
    end else if (load) begin
      pend_flag <= 1'b0;
    end else if (i_Valid && (state == S_SHIFT)) begin
      pend_flag <= 1'b1;
      pend_val  <= i_Value;
    end
  end

  // Any nonzero guard digit means the value exceeds 10^N_DIGITS-1.
  always_comb begin
    ovf_c = 1'b0;
    for (int d = N_DIGITS; d < TOT_DIG; d++) begin
      if (bcd_sr[4*d +: 4] != 4'd0) begin
        ovf_c = 1'b1;
      end
    end
  end

  always_comb begin
    seg_c    = '0;
    nib      = '0;
    nz_above = 1'b0;
    for (int d = N_DIGITS - 1; d >= 0; d--) begin
      nib = bcd_sr[4*d +: 4];
      if (nib != 4'd0) begin
        nz_above = 1'b1;
      end
      if ((LZ_BLANK != 0) && !nz_above && (d != 0)) begin
        seg_c[7*d +: 7] = SEG_BLANK;
      end else begin
        seg_c[7*d +: 7] = seg_of(nib);
      end
    end
`ifdef BCD_SEG_SAT_EN
    if (ovf_c) begin
      seg_c = {N_DIGITS{SEG_NINE}};
    end
`endif
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Seg  <= RST_SEG;
      o_Ovf  <= 1'b0;
      o_Done <= 1'b0;
    end else begin
      o_Done <= do_update;
      if (do_update) begin
        o_Seg <= seg_c;
        o_Ovf <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_bcd_seg_display.sv
// Self-checking bench for bcd_seg_display: blanked and unblanked instances against an arithmetic digit model.
module tb_bcd_seg_display;

  logic        i_Clk;
  logic        i_Rst_n;
  logic [15:0] i_Value;
  logic        i_Valid;

  logic        busy1, done1, ovf1;
  logic [27:0] seg1;
  logic        busy0, done0, ovf0;
  logic [27:0] seg0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [27:0] cur1, cur0;

  localparam logic [27:0] RST1 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [27:0] RST0 = {7'h40, 7'h40, 7'h40, 7'h40};

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  bcd_seg_display #(.BIN_W(16), .N_DIGITS(4), .LZ_BLANK(1)) dut1 (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Value(i_Value), .i_Valid(i_Valid),
    .o_Busy(busy1), .o_Done(done1), .o_Seg(seg1), .o_Ovf(ovf1)
  );

  bcd_seg_display #(.BIN_W(16), .N_DIGITS(4), .LZ_BLANK(0)) dut0 (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Value(i_Value), .i_Valid(i_Valid),
    .o_Busy(busy0), .o_Done(done0), .o_Seg(seg0), .o_Ovf(ovf0)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [27:0] model_seg(input int v, input bit lz);
    logic [27:0] r;
    int w, p, dig;
    r = '0;
`ifdef BCD_SEG_SAT_EN
    if (v > 9999) return {4{7'b0010000}};
`endif
    w = v % 10000;
    p = 1;
    for (int d = 0; d < 4; d++) begin
      dig = (w / p) % 10;
      if (lz && d > 0 && w < p) r[7*d +: 7] = 7'h7F;
      else                      r[7*d +: 7] = seg_tab[dig];
      p = p * 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic convert(input int v);
    int lat, bc;
    bit held;
    logic [27:0] e1, e0;
    e1 = model_seg(v, 1'b1);
    e0 = model_seg(v, 1'b0);
    i_Value = v[15:0];
    i_Valid = 1'b1;
    tick();
    i_Valid = 1'b0;
    bc   = busy1 ? 1 : 0;
    held = (seg1 === cur1) && (seg0 === cur0);
    lat  = 0;
    while (done1 !== 1'b1 && lat < 60) begin
      tick();
      lat++;
      if (done1 !== 1'b1) begin
        if (busy1) bc++;
        if (seg1 !== cur1 || seg0 !== cur0) held = 0;
      end
    end
    chk($sformatf("latency(%0d)", v), lat, 17);
    chk($sformatf("busy_cycles(%0d)", v), bc, 17);
    chk($sformatf("held(%0d)", v), held, 1);
    chk($sformatf("seg_lz1(%0d)", v), seg1, e1);
    chk($sformatf("seg_lz0(%0d)", v), seg0, e0);
    chk($sformatf("ovf1(%0d)", v), ovf1, v > 9999);
    chk($sformatf("ovf0(%0d)", v), ovf0, v > 9999);
    chk($sformatf("done0(%0d)", v), done0, 1);
    chk($sformatf("busy_at_done(%0d)", v), busy1, 0);
    cur1 = e1;
    cur0 = e0;
    tick();
    chk($sformatf("done_pulse(%0d)", v), done1, 0);
  endtask

  initial begin
    int t, ndone, t1, t2, saw200;
    logic [27:0] s1, s2;
    int rv;

    i_Rst_n = 1'b0;
    i_Valid = 1'b0;
    i_Value = '0;
    repeat (3) tick();
    chk("rst_seg1", seg1, RST1);
    chk("rst_seg0", seg0, RST0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_ovf", ovf1, 0);
    i_Rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_seg1", seg1, RST1);
    chk("idle_busy", busy1, 0);
    cur1 = RST1;
    cur0 = RST0;

    convert(1234);
    convert(7);
    convert(0);
    convert(9999);
    convert(10000);
    convert(12345);
    convert(5);
    convert(65535);
    convert(10);
    convert(100);

    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0:       rv = $urandom_range(65535, 0);
        1:       rv = $urandom_range(99, 0);
        default: rv = $urandom_range(10010, 9990);
      endcase
      convert(rv);
    end

    // newest-wins pending: 100, then 200 and 300 while busy
    i_Value = 16'd100; i_Valid = 1'b1; tick(); i_Valid = 1'b0;
    repeat (3) tick();
    i_Value = 16'd200; i_Valid = 1'b1; tick(); i_Valid = 1'b0;
    repeat (3) tick();
    i_Value = 16'd300; i_Valid = 1'b1; tick(); i_Valid = 1'b0;
    t = 8; ndone = 0; t1 = 0; t2 = 0; saw200 = 0; s1 = '0; s2 = '0;
    while (t < 80) begin
      tick();
      t++;
      if (seg1 === model_seg(200, 1'b1)) saw200 = 1;
      if (done1 === 1'b1) begin
        ndone++;
        if (ndone == 1) begin t1 = t; s1 = seg1; end
        if (ndone == 2) begin t2 = t; s2 = seg1; end
      end
    end
    chk("pend_ndone", ndone, 2);
    chk("pend_t1", t1, 17);
    chk("pend_s1", s1, model_seg(100, 1'b1));
    chk("pend_t2", t2, 34);
    chk("pend_s2", s2, model_seg(300, 1'b1));
    chk("pend_no200", saw200, 0);
    cur1 = model_seg(300, 1'b1);
    cur0 = model_seg(300, 1'b0);

    // request arriving in the UPDATE cycle
    i_Value = 16'd42; i_Valid = 1'b1; tick(); i_Valid = 1'b0;
    repeat (16) tick();
    i_Value = 16'd9876; i_Valid = 1'b1; tick(); i_Valid = 1'b0;
    chk("upd_done", done1, 1);
    chk("upd_seg", seg1, model_seg(42, 1'b1));
    chk("upd_busy", busy1, 1);
    t = 17;
    while (done1 !== 1'b1 || t == 17) begin
      if (t >= 80) break;
      tick();
      t++;
    end
    chk("upd_t2", t, 34);
    chk("upd_seg2", seg1, model_seg(9876, 1'b1));
    chk("upd_seg2_lz0", seg0, model_seg(9876, 1'b0));
    cur1 = model_seg(9876, 1'b1);
    cur0 = model_seg(9876, 1'b0);
    tick();

    // mid-conversion reset after an overflow display
    convert(12345);
    i_Value = 16'd4321; i_Valid = 1'b1; tick(); i_Valid = 1'b0;
    repeat (3) tick();
    i_Value = 16'd777; i_Valid = 1'b1; tick(); i_Valid = 1'b0;
    repeat (3) tick();
    i_Rst_n = 1'b0;
    #1;
    chk("mrst_seg1", seg1, RST1);
    chk("mrst_seg0", seg0, RST0);
    chk("mrst_busy", busy1, 0);
    chk("mrst_done", done1, 0);
    chk("mrst_ovf", ovf1, 0);
    repeat (2) tick();
    i_Rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done1 === 1'b1 || busy1 === 1'b1) ndone++;
    end
    chk("mrst_no_activity", ndone, 0);
    chk("mrst_seg_after", seg1, RST1);
    cur1 = RST1;
    cur0 = RST0;
    convert(5);
    convert(123);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_seg_display.md
Name:
bcd_seg_display

Overview:
- Parametrised score/combo readout engine. It replaces per-digit divide/modulo with a sequential double-dabble (shift-add-3) converter.
- Accepts a binary value on a valid strobe and converts it over BIN_W cycles.
- Drives N_DIGITS active-low 7-segment digits, with optional leading-zero blanking and overflow handling.
- One instance per readout: score (4 digits) and combo (2 digits); sits between game logic and HEX pins.

Parameters:
- BIN_W, 16, width of binary input value (>=4).
- N_DIGITS, 4, number of decimal digits driven (1..8).
- LZ_BLANK, 1, 1 = blank leading zeros (digit 0 always shown); 0 = show all zeros.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_n  in  1  reset, asynchronous, active-low.
- i_Value  in  BIN_W  binary value to display.
- i_Valid  in  1  request conversion of i_Value.
- o_Busy  out  1  high while a conversion is in progress.
- o_Done  out  1  one-cycle pulse when o_Seg is updated.
- o_Seg  out  7*N_DIGITS  digit d in bits [7d+6:7d], d=0 least significant; bit0=a .. bit6=g, active-low.
- o_Ovf  out  1  registered; high if last converted value > 10^N_DIGITS-1.

Behaviour:
Clock and reset:
- One clock domain. Reset is asynchronous and active-low on i_Rst_n.
- Reset values:
  - o_Seg = all digits showing "0", or digit 0 = "0" and others blank (7'h7F) if LZ_BLANK=1.
  - o_Busy = 0, o_Done = 0, o_Ovf = 0, state = IDLE, pending flag = 0.

FSM states:
- IDLE:
  - On i_Valid=1 at an edge: capture i_Value into the shift register, clear the BCD register (4*N_DIGITS bits plus internal guard digits so that 2^BIN_W-1 fits).
  - Set counter = BIN_W, go to SHIFT, o_Busy=1.
- SHIFT:
  - Each edge: for every BCD nibble >=5 add 3, then shift {BCD, bin} left 1, decrement counter.
  - After BIN_W shifts go to UPDATE.
- UPDATE (one cycle):
  - Register o_Seg, o_Ovf, and pulse o_Done=1.
  - If the pending flag is set, reload from the pending register and go to SHIFT; otherwise go to IDLE with o_Busy=0.

Latency:
- i_Valid sampled at edge k; o_Seg/o_Done valid after edge k+BIN_W+1.
- Back-to-back i_Valid in IDLE is accepted immediately after UPDATE.

Busy handling:
- i_Valid while busy latches i_Value into the pending register and sets the pending flag; newest value wins.
- No request is lost except superseded ones.
- i_Valid in the UPDATE cycle counts as pending.

Display rules:
- o_Seg holds its old value throughout a conversion; no partial digits are ever visible.
- Digit encoding (active-low g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111
- Leading-zero blanking: digits above the most significant nonzero digit are blank; value 0 shows a single "0" in digit 0.

Overflow:
- Value > 10^N_DIGITS-1 sets o_Ovf=1.
- Displayed digits per the Optional Feature.
- o_Ovf clears on the next in-range conversion.

Reset mid-conversion:
- Aborts immediately to reset values; the pending flag is cleared.

Optional Feature:
- Macro: BCD_SEG_SAT_EN
- Defined: on overflow, o_Seg shows all N_DIGITS as "9" (no blanking).
- Undefined: on overflow, o_Seg shows the low N_DIGITS decimal digits (value mod 10^N_DIGITS), with blanking rules applied to those digits.
- o_Ovf behaves identically in both builds.

Test Plan (BIN_W=16, N_DIGITS=4, LZ_BLANK=1 unless noted):
- Reset release, no stimulus -> o_Seg[6:0]=1000000, digits 1-3 = 1111111, o_Busy=0, o_Ovf=0.
- Single request, i_Valid 1 cycle with i_Value=1234 -> o_Done pulses exactly 17 edges later; digits 3..0 = "1","2","3","4"; o_Busy high for 17 cycles.
- Blanking:
  - i_Value=7 -> digits 1-3 blank, digit 0 = 1111000.
  - With LZ_BLANK=0 -> "0007".
- Pending/newest-wins: i_Valid with 100, then 200 and 300 during busy -> two o_Done pulses; final display "300"; "200" never shown.
- Overflow: i_Value=12345 -> o_Ovf=1.
  - BCD_SEG_SAT_EN defined -> "9999".
  - Undefined -> "2345".
  - Then i_Value=5 -> o_Ovf=0.
- Mid-conversion reset: i_Rst_n low 8 cycles after i_Valid=4321 -> outputs return to reset values asynchronously, no o_Done, previous display discarded.
